// File: rtl/ring_counter_pkg.sv
// Shared constants and pattern helpers for the parametrised ring/Johnson counter.
package ring_counter_pkg;

    localparam logic MODE_RING    = 1'b0;
    localparam logic MODE_JOHNSON = 1'b1;
    localparam logic DIR_UP       = 1'b0;
    localparam logic DIR_DOWN     = 1'b1;

    // Upper bound on WIDTH; callers cast the result down to their own width.
    localparam int MAX_W = 64;

    function automatic int cycle_len(input logic mode, input int width);
        return (mode == MODE_JOHNSON) ? 2 * width : width;
    endfunction

    function automatic logic [MAX_W-1:0] pattern_of(input int pos, input logic mode,
                                                    input int width);
        logic [MAX_W-1:0] pat;
        pat = '0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < width) begin
                if (mode == MODE_RING)
                    pat[i] = (i == pos);
                else if (pos <= width)
                    pat[i] = (i < pos);
                else
                    pat[i] = (i >= pos - width);
            end
        end
        return pat;
    endfunction

endpackage

// File: rtl/ring_counter_param_prescaler.sv
// Step prescaler: tick_o is high on the enabled cycle that completes PRESCALE enabled cycles.
module ring_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk_i,
    input  logic sys_rst_i,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == CW'(PRESCALE - 1));
    assign tick_o = en_i && w_last;

    always_ff @(posedge clk_i) begin
        if (sys_rst_i || clr_i) begin
            r_cnt <= '0;
        end else if (en_i) begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ring_counter_param.sv
// Parametrised one-hot ring / Johnson counter with direction, prescaled stepping, load and wrap strobe.
// Optional pattern self-check and recovery when RING_COUNTER_SELFCHECK_EN is defined.
module ring_counter_param
    import ring_counter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 1,
    parameter int POS_W    = $clog2(2 * WIDTH)
) (
    input  logic             clk_i,
    input  logic             sys_rst_i,
    input  logic             en_i,
    input  logic             dir_i,
    input  logic             mode_i,
    input  logic             load_i,
    input  logic [POS_W-1:0] pos_i,
    output logic [WIDTH-1:0] counter_o,
    output logic [POS_W-1:0] pos_o,
    output logic             wrap_o
`ifdef RING_COUNTER_SELFCHECK_EN
    ,
    output logic             illegal_o
`endif
);

    logic [POS_W-1:0] r_pos;
    logic [WIDTH-1:0] r_counter;
    logic             r_wrap;
    logic             r_mode;

    int               w_len_cur;
    int               w_len_new;
    logic             w_load_ok;
    logic             w_load_bad;
    logic             w_mode_chg;
    logic             w_recover;
    logic             w_tick;
    logic [POS_W-1:0] w_pos_next;
    logic [WIDTH-1:0] w_cnt_next;

    assign w_len_cur  = cycle_len(r_mode, WIDTH);
    assign w_len_new  = cycle_len(mode_i, WIDTH);
    assign w_load_ok  = load_i && (int'(pos_i) < w_len_new);
    assign w_load_bad = load_i && !w_load_ok;
    assign w_mode_chg = (r_mode != mode_i);

`ifdef RING_COUNTER_SELFCHECK_EN
    logic r_illegal;
    logic w_mismatch;

    assign w_mismatch = (r_counter != WIDTH'(pattern_of(int'(r_pos), r_mode, WIDTH)));
    assign w_recover  = w_mismatch;
    assign illegal_o  = r_illegal;

    always_ff @(posedge clk_i) begin
        if (sys_rst_i)
            r_illegal <= 1'b0;
        else
            r_illegal <= w_mismatch;
    end
`else
    assign w_recover = 1'b0;
`endif

    // A rejected load freezes the whole block for that cycle, prescaler included.
    ring_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk_i     (clk_i),
        .sys_rst_i (sys_rst_i),
        .en_i      (en_i && !w_load_bad),
        .clr_i     (w_recover || w_load_ok || w_mode_chg),
        .tick_o    (w_tick)
    );

    always_comb begin
        w_pos_next = r_pos;
        w_cnt_next = r_counter;
        if (dir_i == DIR_UP) begin
            w_pos_next = (int'(r_pos) == w_len_cur - 1) ? '0 : r_pos + 1'b1;
            if (r_mode == MODE_RING)
                w_cnt_next = {r_counter[WIDTH-2:0], r_counter[WIDTH-1]};
            else
                w_cnt_next = {r_counter[WIDTH-2:0], ~r_counter[WIDTH-1]};
        end else begin
            w_pos_next = (r_pos == '0) ? POS_W'(w_len_cur - 1) : r_pos - 1'b1;
            if (r_mode == MODE_RING)
                w_cnt_next = {r_counter[0], r_counter[WIDTH-1:1]};
            else
                w_cnt_next = {~r_counter[0], r_counter[WIDTH-1:1]};
        end
    end

    // The mode register simply follows mode_i; a difference is what triggers re-initialisation.
    always_ff @(posedge clk_i) begin
        if (sys_rst_i) begin
            r_pos     <= '0;
            r_counter <= WIDTH'(pattern_of(0, mode_i, WIDTH));
            r_wrap    <= 1'b0;
            r_mode    <= mode_i;
        end else begin
            r_mode <= mode_i;
            r_wrap <= 1'b0;
            if (w_recover || (!w_load_ok && w_mode_chg)) begin
                r_pos     <= '0;
                r_counter <= WIDTH'(pattern_of(0, mode_i, WIDTH));
            end else if (w_load_ok) begin
                r_pos     <= pos_i;
                r_counter <= WIDTH'(pattern_of(int'(pos_i), mode_i, WIDTH));
            end else if (w_tick && !w_load_bad) begin
                r_pos     <= w_pos_next;
                r_counter <= w_cnt_next;
                r_wrap    <= (w_pos_next == '0);
            end
        end
    end

    assign counter_o = r_counter;
    assign pos_o     = r_pos;
    assign wrap_o    = r_wrap;

endmodule

// File: tb/tb_ring_counter_param.sv
// Bench for ring_counter_param: three instances (8-bit, 4-bit, 8-bit prescaled by 3) share stimulus
// and are checked against an independent position model through an expected-value queue.
module tb_ring_counter_param;

    logic       clk = 1'b0;
    logic       rst, en, dir, mode, load;
    logic [3:0] pos_in;

    logic [7:0] c8;  logic [3:0] p8;  logic w8;
    logic [3:0] c4;  logic [2:0] p4;  logic w4;
    logic [7:0] c3;  logic [3:0] p3;  logic w3;
`ifdef RING_COUNTER_SELFCHECK_EN
    logic       ill8, ill4, ill3;
`endif

    int n_pass  = 0;
    int n_total = 0;

    int cfg_w[3] = '{8, 4, 8};
    int cfg_p[3] = '{1, 1, 3};
    int m_pos[3];
    int m_pre[3];
    int m_mode[3];
    int m_wrap[3];

    // {idx[1:0], counter[7:0], pos[3:0], wrap}
    logic [14:0] exp_q[$];

    always #5 clk = ~clk;

    ring_counter_param #(.WIDTH(8), .PRESCALE(1)) dut8 (
        .clk_i(clk), .sys_rst_i(rst), .en_i(en), .dir_i(dir), .mode_i(mode),
        .load_i(load), .pos_i(pos_in), .counter_o(c8), .pos_o(p8), .wrap_o(w8)
`ifdef RING_COUNTER_SELFCHECK_EN
        , .illegal_o(ill8)
`endif
    );

    ring_counter_param #(.WIDTH(4), .PRESCALE(1)) dut4 (
        .clk_i(clk), .sys_rst_i(rst), .en_i(en), .dir_i(dir), .mode_i(mode),
        .load_i(load), .pos_i(pos_in[2:0]), .counter_o(c4), .pos_o(p4), .wrap_o(w4)
`ifdef RING_COUNTER_SELFCHECK_EN
        , .illegal_o(ill4)
`endif
    );

    ring_counter_param #(.WIDTH(8), .PRESCALE(3)) dut3 (
        .clk_i(clk), .sys_rst_i(rst), .en_i(en), .dir_i(dir), .mode_i(mode),
        .load_i(load), .pos_i(pos_in), .counter_o(c3), .pos_o(p3), .wrap_o(w3)
`ifdef RING_COUNTER_SELFCHECK_EN
        , .illegal_o(ill3)
`endif
    );

    function automatic int ref_pattern(input int p, input int m, input int w);
        int mask;
        mask = (1 << w) - 1;
        if (m == 0) return (1 << p) & mask;
        if (p <= w) return (1 << p) - 1;
        return (mask << (p - w)) & mask;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic model_step(input int i);
        int pin, len_new, len;
        pin     = (cfg_w[i] == 4) ? int'(pos_in[2:0]) : int'(pos_in);
        len_new = mode ? 2 * cfg_w[i] : cfg_w[i];
        if (rst) begin
            m_pos[i] = 0; m_pre[i] = 0; m_wrap[i] = 0; m_mode[i] = int'(mode);
        end else begin
            m_wrap[i] = 0;
            if (load && pin < len_new) begin
                m_pos[i] = pin; m_pre[i] = 0; m_mode[i] = int'(mode);
            end else if (int'(mode) != m_mode[i]) begin
                m_pos[i] = 0; m_pre[i] = 0; m_mode[i] = int'(mode);
            end else if (en && !load) begin
                if (m_pre[i] == cfg_p[i] - 1) begin
                    m_pre[i] = 0;
                    len = m_mode[i] ? 2 * cfg_w[i] : cfg_w[i];
                    m_pos[i] = dir ? (m_pos[i] + len - 1) % len : (m_pos[i] + 1) % len;
                    m_wrap[i] = (m_pos[i] == 0);
                end else begin
                    m_pre[i]++;
                end
            end
        end
        exp_q.push_back({2'(i), 8'(ref_pattern(m_pos[i], m_mode[i], cfg_w[i])),
                         4'(m_pos[i]), 1'(m_wrap[i])});
    endtask

    // Drive one cycle of inputs, clock it, then pop and compare every instance.
    task automatic drive(input logic r, input logic e, input logic d, input logic m,
                         input logic l, input logic [3:0] p);
        logic [14:0] ent;
        logic [12:0] obs;
        rst = r; en = e; dir = d; mode = m; load = l; pos_in = p;
        for (int i = 0; i < 3; i++) model_step(i);
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            ent = exp_q.pop_front();
            case (ent[14:13])
                2'd0:    obs = {c8, p8, w8};
                2'd1:    obs = {4'h0, c4, 1'b0, p4, w4};
                default: obs = {c3, p3, w3};
            endcase
            check($sformatf("model_dut%0d", int'(ent[14:13])), 32'(obs), 32'(ent[12:0]));
        end
    endtask

    initial begin
        logic [3:0] jseq[8];
        jseq = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0};
        rst = 1'b1; en = 1'b0; dir = 1'b0; mode = 1'b0; load = 1'b0; pos_in = '0;
        @(posedge clk);
        #1;

        // Reset state, then ring up through a full cycle.
        drive(1, 0, 0, 0, 0, 0);
        check("reset_cnt8", 32'(c8), 32'h01);
        check("reset_wrap8", 32'(w8), 32'h0);
        for (int k = 1; k <= 8; k++) begin
            drive(0, 1, 0, 0, 0, 0);
            check($sformatf("ring_up_%0d", k), 32'(c8), (k == 8) ? 32'h01 : 32'(1 << k));
        end
        check("ring_wrap8", 32'(w8), 32'h1);
        check("ring_wrap_pos8", 32'(p8), 32'h0);

        // Johnson on the 4-bit instance: mode change, full cycle, then reverse.
        drive(0, 1, 0, 1, 0, 0);
        check("johnson_init4", 32'(c4), 32'h0);
        for (int k = 0; k < 8; k++) begin
            drive(0, 1, 0, 1, 0, 0);
            check($sformatf("johnson_up_%0d", k), 32'(c4), 32'(jseq[k]));
        end
        check("johnson_wrap4", 32'(w4), 32'h1);
        drive(0, 1, 1, 1, 0, 0);
        check("johnson_dn_0", 32'(c4), 32'h8);
        drive(0, 1, 1, 1, 0, 0);
        check("johnson_dn_1", 32'(c4), 32'hC);

        // Prescale by 3 with an enable gap.
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0);
        check("pre_hold_a", 32'(p3), 32'h0);
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        check("pre_hold_b", 32'(c3), 32'h01);
        drive(0, 1, 0, 0, 0, 0);
        check("pre_step", 32'(c3), 32'h02);

        // Loads: valid, out of range, and combined with a mode change.
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 1, 5);
        check("load5_cnt", 32'(c8), 32'h20);
        check("load5_pos", 32'(p8), 32'h5);
        drive(0, 1, 0, 0, 1, 9);
        check("load9_cnt", 32'(c8), 32'h20);
        check("load9_pos", 32'(p8), 32'h5);
        drive(0, 1, 0, 1, 1, 12);
        check("load12_cnt", 32'(c8), 32'hF0);
        check("load12_pos", 32'(p8), 32'hC);
        check("load12_wrap", 32'(w8), 32'h0);

        // Ring down through wrap, then reset mid-count.
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 1, 1, 0, 0, 0);
        check("down_cnt", 32'(c8), 32'h80);
        check("down_pos", 32'(p8), 32'h7);
        check("down_nowrap", 32'(w8), 32'h0);
        for (int k = 0; k < 7; k++) drive(0, 1, 1, 0, 0, 0);
        check("down_wrap", 32'(w8), 32'h1);
        check("down_wrap_cnt", 32'(c8), 32'h01);
        for (int k = 0; k < 3; k++) drive(0, 1, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0);
        check("midreset_cnt", 32'(c8), 32'h01);
        check("midreset_wrap", 32'(w8), 32'h0);

`ifdef RING_COUNTER_SELFCHECK_EN
        drive(1, 0, 0, 0, 0, 0);
        force dut8.r_counter = 8'h03;
        #1;
        release dut8.r_counter;
        drive(0, 0, 0, 0, 0, 0);
        check("illegal_pulse", 32'(ill8), 32'h1);
        drive(0, 0, 0, 0, 0, 0);
        check("illegal_clear", 32'(ill8), 32'h0);
`endif

        // Random mix of all controls against the model.
        for (int k = 0; k < 150; k++) begin
            drive(1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 11) == 0) ? ~mode : mode,
                  1'($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
